// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Holds the core in reset until the PLL has shown a continuous lock for
//   STABLE_CYCLES cycles, issues HOLD_CYCLES-long software reset pulses on
//   request, and records loss of lock in a sticky flag.
//   Optional feature macro: PLL_SEQ_LOSSCNT_EN adds an 8-bit saturating
//   loss-of-lock counter output (loss_cnt).
module pll_lock_sequencer #(
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned HOLD_CYCLES   = 16
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       soft_rst,
  input  logic       clr_lost,
  output logic       core_reset,
  output logic       ready,
  output logic       lost_lock
`ifdef PLL_SEQ_LOSSCNT_EN
  ,
  output logic [7:0] loss_cnt
`endif
);

  localparam logic [15:0] SETTLE_LAST = 16'(STABLE_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    SETTLE,
    RUN,
    HOLD,
    LOST
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] cnt;
  logic [15:0] cnt_next;
  logic [1:0]  sync_q;
  logic        locked_s;
  logic        loss_evt;

  // Two-flop synchronizer for the asynchronous PLL lock input.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], locked};
    end
  end

  assign locked_s = sync_q[1];

  // State and counter registers.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT_LOCK;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and counter logic; loss of lock outranks a soft reset request.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    loss_evt   = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_next = SETTLE;
          cnt_next   = '0;
        end
      end
      SETTLE: begin
        if (!locked_s) begin
          state_next = WAIT_LOCK;
        end else if (cnt == SETTLE_LAST) begin
          state_next = RUN;
        end else if (cnt != '1) begin
          cnt_next = cnt + 16'd1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_next = LOST;
          loss_evt   = 1'b1;
        end else if (soft_rst) begin
          state_next = HOLD;
          cnt_next   = '0;
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_next = LOST;
          loss_evt   = 1'b1;
        end else if (cnt == HOLD_LAST) begin
          state_next = RUN;
        end else if (cnt != '1) begin
          cnt_next = cnt + 16'd1;
        end
      end
      LOST: begin
        state_next = WAIT_LOCK;
      end
      default: begin
        state_next = WAIT_LOCK;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state transition that causes them.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      core_reset <= 1'b1;
      ready      <= 1'b0;
    end else begin
      core_reset <= (state_next != RUN);
      ready      <= (state_next == RUN);
    end
  end

  // Sticky loss flag; a new loss on the clearing edge keeps the flag set.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      lost_lock <= 1'b0;
    end else if (loss_evt) begin
      lost_lock <= 1'b1;
    end else if (clr_lost) begin
      lost_lock <= 1'b0;
    end
  end

`ifdef PLL_SEQ_LOSSCNT_EN
  // Saturating loss counter; clear combined with a new loss restarts at one.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      loss_cnt <= '0;
    end else if (loss_evt) begin
      if (clr_lost) begin
        loss_cnt <= 8'd1;
      end else if (loss_cnt != '1) begin
        loss_cnt <= loss_cnt + 8'd1;
      end
    end else if (clr_lost) begin
      loss_cnt <= '0;
    end
  end
`endif

endmodule
